// File: rtl/pcpi_mul_pkg.sv
// Shared decode constants and FSM encodings for the PCPI RV32M multiplier.
package pcpi_mul_pkg;

  localparam int unsigned AccW = 64;
  localparam int unsigned CntW = 7;

  localparam logic [6:0] OpcodeOp    = 7'b0110011;
  localparam logic [6:0] Funct7MulDiv = 7'b0000001;

  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Mulhu  = 3'b011;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/pcpi_mul_step.sv
// One iteration of the shift-add multiplier: folds StepsPerCycle partial products into acc.
module pcpi_mul_step
  import pcpi_mul_pkg::*;
#(
  parameter int unsigned StepsPerCycle = 4
) (
  input  logic [AccW-1:0]          acc_i,
  input  logic [AccW-1:0]          mcand_i,
  input  logic [StepsPerCycle-1:0] mplier_i,
  output logic [AccW-1:0]          acc_o
);

  always_comb begin
    acc_o = acc_i;
    for (int i = 0; i < StepsPerCycle; i++) begin
      if (mplier_i[i]) begin
        acc_o = acc_o + (mcand_i << i);
      end
    end
  end

endmodule

// File: rtl/pcpi_mul.sv
// Iterative RV32M multiplier on the PicoRV32 PCPI bus (MUL/MULH/MULHSU/MULHU).
// Define PCPI_MUL_FAST_EN to replace the iterative datapath with one registered 33x33 multiply.
module pcpi_mul
  import pcpi_mul_pkg::*;
#(
  parameter int unsigned STEPS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  logic [1:0]      state_q, state_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [AccW-1:0] mcand_q, mcand_d;
  logic [AccW-1:0] mplier_q, mplier_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hi_q, hi_d;
  logic [31:0]     rd_q, rd_d;
  logic            ready_q, ready_d;

  logic [2:0]      funct3;
  logic            insn_match;
  logic            rs1_signed, rs2_signed;
  logic [AccW-1:0] a_ext, b_ext;
  logic [AccW-1:0] acc_step;
  logic [CntW-1:0] cnt_init;
  logic            unused_insn;

  assign funct3     = pcpi_insn[14:12];
  assign insn_match = pcpi_valid && (pcpi_insn[6:0] == OpcodeOp) &&
                      (pcpi_insn[31:25] == Funct7MulDiv) && !funct3[2];
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  assign rs1_signed = (funct3 != F3Mulhu);
  assign rs2_signed = (funct3 == F3Mul) || (funct3 == F3Mulh);
  assign a_ext      = {{32{rs1_signed & pcpi_rs1[31]}}, pcpi_rs1};
  assign b_ext      = {{32{rs2_signed & pcpi_rs2[31]}}, pcpi_rs2};

`ifdef PCPI_MUL_FAST_EN
  logic signed [65:0] prod;
  logic               unused_fast;

  assign prod        = $signed(mcand_q[32:0]) * $signed(mplier_q[32:0]);
  assign acc_step    = prod[AccW-1:0];
  assign cnt_init    = CntW'(1);
  assign unused_fast = ^{prod[65:64], mcand_q[63:33], mplier_q[63:33], acc_q};
`else
  pcpi_mul_step #(
    .StepsPerCycle (STEPS_PER_CYCLE)
  ) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q[STEPS_PER_CYCLE-1:0]),
    .acc_o    (acc_step)
  );

  // Low word only depends on the low 32 multiplier bits, so MUL needs half the steps.
  assign cnt_init = (funct3 == F3Mul) ? CntW'(32 / STEPS_PER_CYCLE) :
                                        CntW'(64 / STEPS_PER_CYCLE);
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    rd_d     = rd_q;
    ready_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (insn_match) begin
          mcand_d  = a_ext;
          mplier_d = b_ext;
          acc_d    = '0;
          hi_d     = (funct3 != F3Mul);
          cnt_d    = cnt_init;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (!pcpi_valid) begin
          state_d = StIdle;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << STEPS_PER_CYCLE;
          mplier_d = mplier_q >> STEPS_PER_CYCLE;
          cnt_d    = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            rd_d    = hi_q ? acc_step[63:32] : acc_step[31:0];
            ready_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (!pcpi_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      hi_q     <= 1'b0;
      rd_q     <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      rd_q     <= rd_d;
      ready_q  <= ready_d;
    end
  end

  assign pcpi_wait  = (state_q == StBusy);
  assign pcpi_ready = ready_q;
  assign pcpi_wr    = ready_q;
  assign pcpi_rd    = rd_q;

endmodule

// File: tb/tb_pcpi_mul.sv
// Directed self-checking bench for pcpi_mul: results, latency, handshake and reset behaviour.
module tb_pcpi_mul;

`ifdef PCPI_MUL_FAST_EN
  localparam int LatMul  = 1;
  localparam int LatMulh = 1;
`else
  localparam int LatMul  = 8;
  localparam int LatMulh = 16;
`endif
  localparam int Budget = 100;

  logic        clk;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  int checks;
  int errors;

  pcpi_mul #(
    .STEPS_PER_CYCLE (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Drives one request from a negedge, measures latency, then releases valid.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit hold_extra);
    int n;
    pcpi_insn  = mk_insn(7'b0000001, f3);
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    pcpi_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, " wait"}, {31'b0, pcpi_wait}, 32'd1);
    pcpi_rs1 = ~a;
    pcpi_rs2 = a ^ b ^ 32'h5a5a_a5a5;
    n = 0;
    while (!pcpi_ready && n < Budget) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check_eq({tag, " latency"}, n, lat);
    check_eq({tag, " rd"}, pcpi_rd, exp);
    check_eq({tag, " wr"}, {31'b0, pcpi_wr}, 32'd1);
    check_eq({tag, " wait_done"}, {31'b0, pcpi_wait}, 32'd0);
    if (hold_extra) begin
      @(negedge clk);
      check_eq({tag, " hold_ready"}, {30'b0, pcpi_ready, pcpi_wr}, 32'd0);
      check_eq({tag, " hold_wait"}, {31'b0, pcpi_wait}, 32'd0);
    end
    pcpi_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, " pulse"}, {31'b0, pcpi_ready}, 32'd0);
    check_eq({tag, " rd_hold"}, pcpi_rd, exp);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn  = '0;
    pcpi_rs1   = '0;
    pcpi_rs2   = '0;
    repeat (2) @(negedge clk);
    check_eq("reset rd", pcpi_rd, 32'h0);
    check_eq("reset flags", {29'b0, pcpi_wait, pcpi_ready, pcpi_wr}, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    run_op("mul_3x7",      3'b000, 32'd3,          32'd7,          32'h0000_0015, LatMul,  1'b0);
    run_op("mul_m3x7",     3'b000, 32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFEB, LatMul,  1'b0);
    run_op("mul_1000sq",   3'b000, 32'd1000,       32'd1000,       32'h000F_4240, LatMul,  1'b0);
    run_op("mul_shift",    3'b000, 32'h1234_5678,  32'h0000_0010,  32'h2345_6780, LatMul,  1'b0);
    run_op("mulh_m10xm4",  3'b001, 32'hFFFF_FFF6,  32'hFFFF_FFFC,  32'h0000_0000, LatMulh, 1'b0);
    run_op("mulh_min",     3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, LatMulh, 1'b0);
    run_op("mulhsu_m10x4", 3'b010, 32'hFFFF_FFF6,  32'd4,          32'hFFFF_FFFF, LatMulh, 1'b0);
    run_op("mulhsu_m1xu",  3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, LatMulh, 1'b0);
    run_op("mulhu_max",    3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, LatMulh, 1'b0);
    run_op("mul_hold",     3'b000, 32'd9,          32'd9,          32'h0000_0051, LatMul,  1'b1);

    // Non-M encodings must never be claimed.
    pcpi_insn  = mk_insn(7'b0000000, 3'b000);
    pcpi_rs1   = 32'd4;
    pcpi_rs2   = 32'd5;
    pcpi_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("add_ignored", {29'b0, pcpi_wait, pcpi_ready, pcpi_wr}, 32'h0);
    end
    pcpi_insn = mk_insn(7'b0000001, 3'b100);
    repeat (3) @(negedge clk);
    check_eq("div_ignored", {29'b0, pcpi_wait, pcpi_ready, pcpi_wr}, 32'h0);
    check_eq("ignored_rd", pcpi_rd, 32'h0000_0051);
    pcpi_valid = 1'b0;
    @(negedge clk);

    // Abort by dropping valid mid-operation: no ready, rd unchanged.
    pcpi_insn  = mk_insn(7'b0000001, 3'b011);
    pcpi_rs1   = 32'd77;
    pcpi_rs2   = 32'd88;
    pcpi_valid = 1'b1;
    repeat (3) @(negedge clk);
    pcpi_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pcpi_ready) check_eq("abort_ready", {31'b0, pcpi_ready}, 32'd0);
    end
    check_eq("abort_idle", {29'b0, pcpi_wait, pcpi_ready, pcpi_wr}, 32'h0);
    check_eq("abort_rd", pcpi_rd, 32'h0000_0051);

    // Asynchronous reset in the middle of a long operation.
    pcpi_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("pre_reset_wait", {31'b0, pcpi_wait}, 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("rst_flags", {29'b0, pcpi_wait, pcpi_ready, pcpi_wr}, 32'h0);
    check_eq("rst_rd", pcpi_rd, 32'h0);
    pcpi_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_op("mul_5x6", 3'b000, 32'd5, 32'd6, 32'h0000_001E, LatMul, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
